// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states, width.
package muldiv_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B
  function automatic logic is_muldiv(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, sign fix-up.
module muldiv_sequencer_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_sequencer_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            fix,
  input  logic            is_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic              op_div;
  logic              sign_q;
  logic              sign_r;
  logic              div_zero;
  logic [XLEN-1:0]   raw_rs;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    mag_a = (is_signed && rs[XLEN-1]) ? -rs : rs;
    mag_b = (is_signed && rt[XLEN-1]) ? -rt : rt;
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_trial = div_shift - {1'b0, opb};
  end

  // acc is the product register for multiply; its low half is the dividend/quotient shifter for divide
  always_ff @(posedge clk) begin
    if (rst) begin
      op_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      raw_rs   <= '0;
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
    end else if (start) begin
      op_div   <= is_div;
      sign_q   <= is_signed & (rs[XLEN-1] ^ rt[XLEN-1]);
      sign_r   <= is_signed & rs[XLEN-1];
      div_zero <= (rt == '0);
      raw_rs   <= rs;
      opb      <= mag_b;
      acc      <= {{XLEN{1'b0}}, mag_a};
      rem      <= '0;
    end else if (step) begin
      if (op_div) begin
        rem <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~div_trial[XLEN]};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_r ? -rem : rem;
    res_hi   = '0;
    res_lo   = '0;
    if (fix) begin
      if (!op_div) begin
        res_hi = prod_fix[2*XLEN-1:XLEN];
        res_lo = prod_fix[XLEN-1:0];
      end else if (div_zero) begin
        res_hi = raw_rs;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the EX stage: sequences MULT/DIV, serves MF*/MT*, and raises the EX stall.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN  = muldiv_sequencer_pkg::XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [5:0]      funct_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;

  logic            eff;
  logic            start;
  logic            step;
  logic            fix;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  assign busy_o  = busy;
  assign stall_o = busy & req_i;
  assign hi_o    = hi;
  assign lo_o    = lo;

  always_comb begin
    eff     = req_i & ~flush_i & ~stall_o;
    start   = (state == ST_IDLE) & eff & is_muldiv(funct_i);
    step    = (state == ST_MUL) || (state == ST_DIV);
    fix     = (state == ST_FIX);
    rdata_o = '0;
    if (req_i && !busy) begin
      if (funct_i == FN_MFHI)
        rdata_o = hi;
      else if (funct_i == FN_MFLO)
        rdata_o = lo;
    end
  end

  muldiv_sequencer_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (step),
    .fix       (fix),
    .is_div    (funct_i[1]),
    .is_signed (~funct_i[0]),
    .rs        (rs_i),
    .rt        (rt_i),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eff) begin
            case (funct_i)
              FN_MTHI: hi <= rs_i;
              FN_MTLO: lo <= rs_i;
              FN_MULT, FN_MULTU: begin
                state <= ST_MUL;
                busy  <= 1'b1;
                cnt   <= '0;
              end
              FN_DIV, FN_DIVU: begin
                state <= ST_DIV;
                busy  <= 1'b1;
                cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST)
            state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
